// File: rtl/nanorv32_irq_seq_if.sv
// Flow-controller <-> interrupt-entry sequencer bus for the nanorv32 core.
// master: pipeline flow controller side; slave: the sequencer.
interface nanorv32_irq_seq_if #(
    parameter int unsigned UROM_ADDR_W = 5
);
    logic                   irq;
    logic                   irq_enable;
    logic                   inst_boundary;
    logic                   branch_pending;
    logic                   uinst_done;
    logic                   mret;
    logic [UROM_ADDR_W-1:0] urom_addr;
    logic                   irq_bypass_inst_reg;
    logic                   irq_ack;
    logic                   irq_active;
    logic [15:0]            irq_count;

    modport master (
        output irq, irq_enable, inst_boundary, branch_pending, uinst_done, mret,
        input  urom_addr, irq_bypass_inst_reg, irq_ack, irq_active, irq_count
    );

    modport slave (
        input  irq, irq_enable, inst_boundary, branch_pending, uinst_done, mret,
        output urom_addr, irq_bypass_inst_reg, irq_ack, irq_active, irq_count
    );
endinterface

// File: rtl/nanorv32_irq_seq.sv
// Interrupt-entry sequencer: waits for a clean instruction boundary, then steps the
// micro-ROM entry sequence. Optional entry counter enabled by NANORV32_IRQ_COUNT_EN.
module nanorv32_irq_seq #(
    parameter int unsigned UROM_ADDR_W = 5,
    parameter int unsigned ENTRY_ADDR  = 0,
    parameter int unsigned SEQ_LEN     = 8
) (
    input  logic              clk,
    input  logic              rst,
    nanorv32_irq_seq_if.slave bus
);
    localparam logic [UROM_ADDR_W-1:0] ENTRY = UROM_ADDR_W'(ENTRY_ADDR);
    localparam logic [UROM_ADDR_W-1:0] LAST  = UROM_ADDR_W'(ENTRY_ADDR + SEQ_LEN - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BND = 2'd1,
        SEQ      = 2'd2,
        HANDLER  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [UROM_ADDR_W-1:0] addr_q;
    logic [UROM_ADDR_W-1:0] addr_nxt;
    logic                   ack_nxt;
    logic                   ack_q;
    logic                   bypass_q;
    logic                   active_q;

    // Next-state and address decode; cancel beats boundary in WAIT_BND.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        ack_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.irq && bus.irq_enable) state_nxt = WAIT_BND;
            end
            WAIT_BND: begin
                if (!bus.irq || !bus.irq_enable) begin
                    state_nxt = IDLE;
                end else if (bus.inst_boundary && !bus.branch_pending) begin
                    state_nxt = SEQ;
                    addr_nxt  = ENTRY;
                end
            end
            SEQ: begin
                if (bus.uinst_done) begin
                    if (addr_q == LAST) begin
                        state_nxt = HANDLER;
                        ack_nxt   = 1'b1;
                        addr_nxt  = ENTRY;
                    end else begin
                        addr_nxt = addr_q + UROM_ADDR_W'(1);
                    end
                end
            end
            HANDLER: begin
                if (bus.mret) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they align with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= ENTRY;
            ack_q    <= 1'b0;
            bypass_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr_q   <= addr_nxt;
            ack_q    <= ack_nxt;
            bypass_q <= (state_nxt == SEQ);
            active_q <= (state_nxt == HANDLER);
        end
    end

`ifdef NANORV32_IRQ_COUNT_EN
    logic [15:0] count_q;

    // Counts completed entries; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 16'd0;
        end else if (ack_nxt) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign bus.irq_count = count_q;
`else
    assign bus.irq_count = 16'd0;
`endif

    assign bus.urom_addr           = addr_q;
    assign bus.irq_bypass_inst_reg = bypass_q;
    assign bus.irq_ack             = ack_q;
    assign bus.irq_active          = active_q;

endmodule

// File: tb/tb_nanorv32_irq_seq.sv
// Bench for nanorv32_irq_seq: directed test-plan scenarios plus random stimulus,
// every cycle compared against a sequence-position reference model.
module tb_nanorv32_irq_seq;
    localparam int unsigned UROM_ADDR_W = 5;
    localparam int unsigned ENTRY_ADDR  = 0;
    localparam int unsigned SEQ_LEN     = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    nanorv32_irq_seq_if #(.UROM_ADDR_W(UROM_ADDR_W)) bus ();

    nanorv32_irq_seq #(
        .UROM_ADDR_W(UROM_ADDR_W),
        .ENTRY_ADDR (ENTRY_ADDR),
        .SEQ_LEN    (SEQ_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: request pending, position in the micro-sequence, handler running.
    bit m_pending;
    bit m_handler;
    bit m_ack;
    int m_pos;
    int m_entries;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, want);
        end
    endtask

    task automatic check_all();
        int exp_cnt;
        check("urom_addr", 32'(bus.urom_addr), 32'(ENTRY_ADDR + ((m_pos >= 0) ? m_pos : 0)));
        check("bypass", 32'(bus.irq_bypass_inst_reg), 32'(m_pos >= 0));
        check("irq_ack", 32'(bus.irq_ack), 32'(m_ack));
        check("irq_active", 32'(bus.irq_active), 32'(m_handler));
`ifdef NANORV32_IRQ_COUNT_EN
        exp_cnt = m_entries % 65536;
`else
        exp_cnt = 0;
`endif
        check("irq_count", 32'(bus.irq_count), 32'(exp_cnt));
    endtask

    task automatic model_step(input bit i, input bit e, input bit b, input bit br,
                              input bit d, input bit m, input bit r);
        if (r) begin
            m_pending = 0; m_handler = 0; m_ack = 0; m_pos = -1; m_entries = 0;
            return;
        end
        m_ack = 0;
        if (m_pos >= 0) begin
            if (d) begin
                if (m_pos == int'(SEQ_LEN) - 1) begin
                    m_pos = -1; m_handler = 1; m_ack = 1; m_entries++;
                end else begin
                    m_pos++;
                end
            end
        end else if (m_handler) begin
            if (m) m_handler = 0;
        end else if (m_pending) begin
            if (!i || !e) m_pending = 0;
            else if (b && !br) begin
                m_pending = 0; m_pos = 0;
            end
        end else if (i && e) begin
            m_pending = 1;
        end
    endtask

    // One clock: drive inputs, advance model with the sampled inputs, check at negedge.
    task automatic tick(input bit i, input bit e, input bit b, input bit br,
                        input bit d, input bit m, input bit r);
        bus.irq = i; bus.irq_enable = e; bus.inst_boundary = b;
        bus.branch_pending = br; bus.uinst_done = d; bus.mret = m; rst = r;
        @(posedge clk);
        model_step(i, e, b, br, d, m, r);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 1, 0, 0, 0, 0, 0);
    endtask

    // Enter SEQ with minimum latency, then retire the whole sequence back to back.
    task automatic full_entry();
        tick(1, 1, 0, 0, 0, 0, 0);
        tick(1, 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < int'(SEQ_LEN); k++) tick(0, 0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        checks = 0; errors = 0;
        m_pending = 0; m_handler = 0; m_ack = 0; m_pos = -1; m_entries = 0;
        bus.irq = 0; bus.irq_enable = 0; bus.inst_boundary = 0;
        bus.branch_pending = 0; bus.uinst_done = 0; bus.mret = 0; rst = 1;
        @(negedge clk);

        tick(0, 0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 0, 1);
        check("reset_addr", 32'(bus.urom_addr), 32'(ENTRY_ADDR));
        idle(3);

        // Basic entry, with a 3-cycle stall at address 3.
        tick(1, 1, 0, 0, 0, 0, 0);
        tick(1, 1, 1, 0, 0, 0, 0);
        check("seq_start_bypass", 32'(bus.irq_bypass_inst_reg), 32'd1);
        for (int k = 0; k < 3; k++) tick(1, 1, 0, 0, 1, 0, 0);
        check("stall_addr", 32'(bus.urom_addr), 32'(ENTRY_ADDR + 3));
        for (int k = 0; k < 3; k++) tick(1, 1, 0, 0, 0, 1, 0);
        check("stall_hold", 32'(bus.urom_addr), 32'(ENTRY_ADDR + 3));
        for (int k = 3; k < int'(SEQ_LEN); k++) tick(0, 0, 0, 0, 1, 1, 0);
        check("ack_pulse", 32'(bus.irq_ack), 32'd1);
        check("active_on", 32'(bus.irq_active), 32'd1);
        tick(0, 0, 0, 0, 0, 0, 0);
        check("ack_low", 32'(bus.irq_ack), 32'd0);

        // mret with irq still high: active drops, then WAIT_BND, then SEQ on boundary.
        tick(1, 1, 0, 0, 0, 1, 0);
        check("mret_active_off", 32'(bus.irq_active), 32'd0);
        tick(1, 1, 0, 0, 0, 0, 0);
        tick(1, 1, 1, 1, 0, 0, 0);
        check("branch_blocks", 32'(bus.irq_bypass_inst_reg), 32'd0);
        tick(1, 1, 1, 0, 0, 0, 0);
        check("reentry_bypass", 32'(bus.irq_bypass_inst_reg), 32'd1);
        for (int k = 0; k < int'(SEQ_LEN); k++) tick(0, 0, 0, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 0, 1, 0);
        idle(2);

        // Cancel in WAIT_BND by irq low, and by irq falling together with a boundary.
        tick(1, 1, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0, 0, 0);
        tick(0, 1, 1, 0, 0, 0, 0);
        check("cancel_no_bypass", 32'(bus.irq_bypass_inst_reg), 32'd0);
        tick(1, 1, 0, 0, 0, 0, 0);
        tick(1, 0, 1, 0, 0, 0, 0);
        idle(2);

        // Reset at address 5 mid-sequence.
        tick(1, 1, 0, 0, 0, 0, 0);
        tick(1, 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) tick(0, 0, 0, 0, 1, 0, 0);
        check("pre_reset_addr", 32'(bus.urom_addr), 32'(ENTRY_ADDR + 5));
        tick(0, 0, 0, 0, 1, 0, 1);
        check("mid_reset_bypass", 32'(bus.irq_bypass_inst_reg), 32'd0);
        for (int k = 0; k < int'(SEQ_LEN); k++) tick(0, 0, 0, 0, 1, 0, 0);

        // Three completed entries for the counter.
        for (int n = 0; n < 3; n++) begin
            full_entry();
            tick(0, 0, 0, 0, 0, 1, 0);
        end
`ifdef NANORV32_IRQ_COUNT_EN
        check("count_three", 32'(bus.irq_count), 32'd3);
        @(negedge clk);
        force dut.count_q = 16'hFFFF;
        @(posedge clk);
        release dut.count_q;
        m_entries = 65535;
        @(negedge clk);
        check_all();
        full_entry();
        check("count_wrap", 32'(bus.irq_count), 32'd0);
        tick(0, 0, 0, 0, 0, 1, 0);
`else
        check("count_zero", 32'(bus.irq_count), 32'd0);
`endif

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            tick($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 299) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nanorv32_irq_seq.md
# nanorv32_irq_seq

Interrupt-entry sequencer for the nanorv32 core. It drives the micro-ROM address counter and the instruction-register bypass. On an accepted interrupt it waits for a clean instruction boundary, then steps a fixed-length micro-instruction sequence from the micro-ROM into the pipeline, one entry per retired micro-instruction. It sits between the pipeline flow controller and the micro-ROM.

## Interface
Parameters:
- UROM_ADDR_W, 5 — micro-ROM address width.
- ENTRY_ADDR, 0 — first micro-ROM address of the entry sequence.
- SEQ_LEN, 8 — number of micro-instructions in the sequence; legal range 1..2^UROM_ADDR_W − ENTRY_ADDR.

Ports:
- clk  in  1  — core clock; all state updates on its rising edge.
- rst  in  1  — reset, synchronous and active-high.
- irq  in  1  — level interrupt request, already synchronous to clk.
- irq_enable  in  1  — global interrupt enable.
- inst_boundary  in  1  — flow controller is in its continue state with a valid instruction and no stall.
- branch_pending  in  1  — a taken branch is being redirected this cycle.
- uinst_done  in  1  — the pipeline consumed the current micro-instruction this cycle.
- mret  in  1  — handler return executed; single-cycle pulse.
- urom_addr  out  UROM_ADDR_W  — micro-ROM address, registered.
- irq_bypass_inst_reg  out  1  — instruction register takes micro-ROM data instead of fetched code.
- irq_ack  out  1  — one-cycle pulse when the entry sequence completes.
- irq_active  out  1  — handler in progress; further interrupts are blocked.
- irq_count  out  16  — number of completed interrupt entries; see Configuration.

## Operation
- States: IDLE, WAIT_BND, SEQ, HANDLER. Encoded in registers; all outputs decode from registers, none are combinational from inputs.
- IDLE:
  - irq && irq_enable → WAIT_BND.
  - Otherwise stay in IDLE.
- WAIT_BND:
  - irq low or irq_enable low → IDLE. The request is cancelled and no ack is issued.
  - Else inst_boundary && !branch_pending → SEQ, with urom_addr loaded to ENTRY_ADDR.
  - Else stay in WAIT_BND.
  - A cancel condition has priority over a boundary in the same cycle.
- SEQ:
  - irq_bypass_inst_reg = 1.
  - On uinst_done with urom_addr ≠ ENTRY_ADDR+SEQ_LEN−1: urom_addr increments by 1.
  - On uinst_done with urom_addr = ENTRY_ADDR+SEQ_LEN−1: go to HANDLER, irq_ack pulses for one cycle, and urom_addr reloads ENTRY_ADDR.
  - irq, irq_enable and mret are ignored; the sequence cannot be aborted except by rst.
- HANDLER:
  - irq_active = 1.
  - mret → IDLE. If irq is still high, IDLE re-evaluates it on the next cycle.
  - mret in any other state is ignored.
- Arithmetic: the urom_addr increment is UROM_ADDR_W wide and never wraps, because the SEQ_LEN bound is enforced by the terminal compare.
- SEQ_LEN = 1: the first uinst_done in SEQ goes directly to HANDLER.

## Timing
- Reset values, applied in the cycle after rst is sampled high:
  - state = IDLE, urom_addr = ENTRY_ADDR.
  - irq_bypass_inst_reg = 0, irq_ack = 0, irq_active = 0, irq_count = 0.
- Reset mid-sequence: same values. The next cycle's bypass is 0, so no partial sequence resumes.
- Minimum entry latency: irq sampled high in IDLE at cycle N → WAIT_BND at N+1. With inst_boundary at N+1 → SEQ at N+2, with bypass high and urom_addr = ENTRY_ADDR.
- Each uinst_done advances urom_addr in the following cycle. A stalled pipeline (uinst_done low) holds the address indefinitely.
- The last uinst_done at cycle M gives irq_ack = 1 and irq_active = 1 at M+1. irq_ack is low at M+2.
- mret at cycle K in HANDLER gives irq_active = 0 at K+1.

## Configuration
- Macro: NANORV32_IRQ_COUNT_EN.
- Defined: irq_count is a 16-bit register that increments in the cycle irq_ack asserts. It wraps from 0xFFFF to 0x0000 and is cleared by rst.
- Undefined: the counter logic is removed and irq_count is a constant 0. The port is still present.

## Test plan
- Basic entry: irq high at cycle 10 with irq_enable = 1; inst_boundary at 11; uinst_done every cycle with SEQ_LEN = 8 → bypass high for cycles 12–19, urom_addr steps 0..7, irq_ack at cycle 20 only, irq_active from 20.
- Stall and cancel:
  - uinst_done low for 3 cycles at address 3 → address holds at 3 for those cycles, then continues to 4.
  - irq dropped while in WAIT_BND → IDLE, no bypass, no ack.
- Boundary priority: inst_boundary and branch_pending both high → stays in WAIT_BND. The next boundary without branch_pending enters SEQ. irq falling in the same cycle as a boundary → IDLE.
- Return and re-entry:
  - mret in HANDLER with irq still high → irq_active low one cycle later, then WAIT_BND the cycle after.
  - mret pulsed in IDLE or SEQ → no effect.
- Reset at urom_addr = 5 mid-SEQ → next cycle urom_addr = 0 and bypass = 0; no ack pulse follows.
- Counter with NANORV32_IRQ_COUNT_EN defined:
  - 3 completed entries → irq_count = 3.
  - Preload to 0xFFFF via 65535 entries, or via a force in the bench, plus one more entry → 0x0000.
  - Macro undefined → irq_count stays 0 throughout.
